// File: rtl/instruction_memory_ws.sv
// Instruction fetch slave: valid/ready request and response channels, programmable wait states,
// a run-time load port, misaligned/out-of-range fault detection and a pipeline flush.
module instruction_memory_ws #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 256,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] NOP_WORD    = '0,
  localparam int               IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] WAIT_LOAD    = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam state_e     ACCEPT_STATE = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_instr_q;
  logic [ADDR_W-1:0] rsp_pc_q;
  logic              rsp_fault_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              fault;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rd_word;

  // Program load and response backpressure both block new fetches; flush drops the request too.
  assign req_ready = !reset && !flush && !prog_we &&
                     (state_q == S_IDLE || (state_q == S_RESP && rsp_ready));
  assign accept    = req_valid && req_ready;

  assign fault    = (|req_pc[1:0]) || ((req_pc >> 2) >= ADDR_W'(DEPTH));
  assign word_idx = req_pc[IDX_W+1:2];
  assign rd_word  = fault ? NOP_WORD : mem_q[word_idx];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = ACCEPT_STATE;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (accept) begin
            state_d = ACCEPT_STATE;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rsp_instr_q <= NOP_WORD;
      rsp_pc_q    <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Data is captured at accept, so later program writes cannot alter a pending response.
      if (accept) begin
        rsp_instr_q <= rd_word;
        rsp_pc_q    <= req_pc;
        rsp_fault_q <= fault;
      end
    end
  end

  // NOTE: the storage array has no reset so loaded programs survive a core reset and map to RAM.
  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_instr = rsp_instr_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_instruction_memory_ws.sv
// Directed bench: a zero-wait instance driven from a vector table, and a three-wait-state
// instance exercising latency, backpressure, flush, load collision and reset sequences.
module tb_instruction_memory_ws;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Zero-wait instance signals
  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_fault0, flush0, prog_we0;
  logic [31:0] req_pc0, rsp_instr0, rsp_pc0, prog_data0;
  logic [7:0]  prog_addr0;
  // Three-wait instance signals
  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_fault3, flush3, prog_we3;
  logic [31:0] req_pc3, rsp_instr3, rsp_pc3, prog_data3;
  logic [7:0]  prog_addr3;

  instruction_memory_ws #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0),
                          .NOP_WORD(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_pc(req_pc0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_instr(rsp_instr0),
    .rsp_pc(rsp_pc0), .rsp_fault(rsp_fault0), .flush(flush0),
    .prog_we(prog_we0), .prog_addr(prog_addr0), .prog_data(prog_data0)
  );

  instruction_memory_ws #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(3),
                          .NOP_WORD(32'h0000_0013)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_pc(req_pc3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_instr(rsp_instr3),
    .rsp_pc(rsp_pc3), .rsp_fault(rsp_fault3), .flush(flush3),
    .prog_we(prog_we3), .prog_addr(prog_addr3), .prog_data(prog_data3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog0(input logic [7:0] a, input logic [31:0] d);
    prog_we0 = 1'b1; prog_addr0 = a; prog_data0 = d;
    step();
    prog_we0 = 1'b0;
  endtask

  task automatic prog3(input logic [7:0] a, input logic [31:0] d);
    prog_we3 = 1'b1; prog_addr3 = a; prog_data3 = d;
    step();
    prog_we3 = 1'b0;
  endtask

  // Present one request on the wait-state instance and let it be accepted on the next edge.
  task automatic accept3(input logic [31:0] pc, input string nm);
    req_valid3 = 1'b1;
    req_pc3    = pc;
    #1;
    check({nm, " req_ready"}, 64'(req_ready3), 64'd1);
    step();
    req_valid3 = 1'b0;
  endtask

  // Count edges until rsp_valid, checking req_ready stays low meanwhile; bounded at 20.
  task automatic wait_rsp3(input int exp_lat, input string nm);
    int n;
    n = 0;
    while (!rsp_valid3 && n < 20) begin
      check({nm, " req_ready in wait"}, 64'(req_ready3), 64'd0);
      step();
      n++;
    end
    check({nm, " latency"}, 64'(n), 64'(exp_lat));
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_instr;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h8C01_0000, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h8C02_0001, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'hAC01_0000, 1'b0};
    vecs[3] = '{32'h0000_000C, 32'h1000_FFD8, 1'b0};
    vecs[4] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_03FC, 32'h1234_5678, 1'b0};

    reset = 1'b1;
    {req_valid0, rsp_ready0, flush0, prog_we0} = '0;
    {req_valid3, rsp_ready3, flush3, prog_we3} = '0;
    req_pc0 = '0; prog_addr0 = '0; prog_data0 = '0;
    req_pc3 = '0; prog_addr3 = '0; prog_data3 = '0;

    // Reset: a pending request must not be accepted during the reset cycle.
    req_valid0 = 1'b1;
    req_valid3 = 1'b1;
    step();
    check("reset req_ready0", 64'(req_ready0), 64'd0);
    check("reset req_ready3", 64'(req_ready3), 64'd0);
    req_valid0 = 1'b0;
    req_valid3 = 1'b0;
    step();
    reset = 1'b0;
    check("reset rsp_valid0", 64'(rsp_valid0), 64'd0);
    check("reset rsp_fault0", 64'(rsp_fault0), 64'd0);
    check("reset rsp_pc3", 64'(rsp_pc3), 64'd0);
    check("reset rsp_instr3", 64'(rsp_instr3), 64'h13);
    check("reset rsp_valid3", 64'(rsp_valid3), 64'd0);

    // Program load; the last write is immediately followed by a fetch (write-then-read).
    prog0(8'd255, 32'h1234_5678);
    prog0(8'd1, 32'h8C02_0001);
    prog0(8'd2, 32'hAC01_0000);
    prog0(8'd3, 32'h1000_FFD8);
    prog0(8'd0, 32'h8C01_0000);

    // Zero-wait streaming fetch: one response per cycle, visible right after the accept edge.
    rsp_ready0 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req_valid0 = 1'b1;
      req_pc0    = vecs[i].pc;
      #1;
      check($sformatf("vec%0d req_ready", i), 64'(req_ready0), 64'd1);
      step();
      check($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid0), 64'd1);
      check($sformatf("vec%0d rsp_instr", i), 64'(rsp_instr0), 64'(vecs[i].exp_instr));
      check($sformatf("vec%0d rsp_pc", i), 64'(rsp_pc0), 64'(vecs[i].pc));
      check($sformatf("vec%0d rsp_fault", i), 64'(rsp_fault0), 64'(vecs[i].exp_fault));
    end
    req_valid0 = 1'b0;
    step();
    check("stream drain rsp_valid0", 64'(rsp_valid0), 64'd0);

    // Wait-state instance: latency and req_ready low while waiting.
    prog3(8'd2, 32'hAAAA_0002);
    prog3(8'd3, 32'hAAAA_0003);
    accept3(32'h8, "ws pc8");
    wait_rsp3(3, "ws pc8");
    check("ws pc8 rsp_pc", 64'(rsp_pc3), 64'h8);
    check("ws pc8 rsp_instr", 64'(rsp_instr3), 64'hAAAA_0002);
    check("ws pc8 rsp_fault", 64'(rsp_fault3), 64'd0);

    // Backpressure: response holds, next request waits, then is accepted on release.
    req_valid3 = 1'b1;
    req_pc3    = 32'hC;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d req_ready", k), 64'(req_ready3), 64'd0);
      step();
      check($sformatf("bp%0d rsp_valid", k), 64'(rsp_valid3), 64'd1);
      check($sformatf("bp%0d rsp_instr", k), 64'(rsp_instr3), 64'hAAAA_0002);
      check($sformatf("bp%0d rsp_pc", k), 64'(rsp_pc3), 64'h8);
    end
    rsp_ready3 = 1'b1;
    #1;
    check("bp release req_ready", 64'(req_ready3), 64'd1);
    step();
    req_valid3 = 1'b0;
    check("bp release rsp_valid drops", 64'(rsp_valid3), 64'd0);
    wait_rsp3(3, "bp pc12");
    check("bp pc12 rsp_instr", 64'(rsp_instr3), 64'hAAAA_0003);
    check("bp pc12 rsp_pc", 64'(rsp_pc3), 64'hC);
    step();
    check("bp consumed rsp_valid", 64'(rsp_valid3), 64'd0);

    // Flush during WAIT: no response ever appears, and the next fetch works.
    accept3(32'h8, "flush pc8");
    step();
    flush3     = 1'b1;
    req_valid3 = 1'b1;
    req_pc3    = 32'hC;
    #1;
    check("flush req_ready", 64'(req_ready3), 64'd0);
    step();
    flush3     = 1'b0;
    req_valid3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("flush quiet%0d rsp_valid", k), 64'(rsp_valid3), 64'd0);
      step();
    end
    accept3(32'hC, "post-flush pc12");
    wait_rsp3(3, "post-flush pc12");
    check("post-flush rsp_instr", 64'(rsp_instr3), 64'hAAAA_0003);
    step();

    // Program write to the word being fetched while in WAIT: pending response keeps old data.
    accept3(32'h8, "coll pc8");
    prog_we3 = 1'b1; prog_addr3 = 8'd2; prog_data3 = 32'hDEAD_BEEF;
    step();
    prog_we3 = 1'b0;
    wait_rsp3(2, "coll pc8");
    check("coll old word", 64'(rsp_instr3), 64'hAAAA_0002);
    step();
    accept3(32'h8, "refetch pc8");
    wait_rsp3(3, "refetch pc8");
    check("refetch new word", 64'(rsp_instr3), 64'hDEAD_BEEF);
    step();

    // Reset while holding a response: output cleared, storage retained.
    rsp_ready3 = 1'b0;
    accept3(32'h8, "rst pc8");
    wait_rsp3(3, "rst pc8");
    check("rst pre rsp_valid", 64'(rsp_valid3), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst rsp_valid", 64'(rsp_valid3), 64'd0);
    check("rst rsp_pc", 64'(rsp_pc3), 64'd0);
    check("rst rsp_instr", 64'(rsp_instr3), 64'h13);
    rsp_ready3 = 1'b1;
    accept3(32'h8, "rst retain pc8");
    wait_rsp3(3, "rst retain pc8");
    check("rst retain word3", 64'(rsp_instr3), 64'hDEAD_BEEF);
    req_valid0 = 1'b1;
    req_pc0    = 32'h4;
    step();
    req_valid0 = 1'b0;
    check("rst retain dut0 valid", 64'(rsp_valid0), 64'd1);
    check("rst retain dut0 word", 64'(rsp_instr0), 64'h8C02_0001);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
